// File: rtl/axil_pkg.sv
// Shared constants and types for the AXI-Lite UART transmitter: response codes,
// register offsets, STATUS bit positions and the serializer state type.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_DIVISOR = 2'd2;

  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_BUSY    = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 8;
  localparam int unsigned ST_CNT_W   = 5;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_t;

  // A zero divisor behaves as one clock per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: takes one byte per valid/ready handshake and shifts it out
// LSB first, each bit lasting the divisor latched at frame start.
module uart_tx_serializer
  import axil_pkg::*;
(
  input  logic        AXI_CLK,
  input  logic        RESET,
  input  logic [7:0]  tx_byte,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [15:0] divisor,
  output logic        txd,
  output logic        busy
);

  ser_state_t  state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        bit_end;

  assign bit_end = (cnt_q == div_q - 16'd1);
  assign busy    = (state_q != SER_IDLE);

  always_ff @(posedge AXI_CLK) begin
    if (RESET) begin
      state_q <= SER_IDLE;
      div_q   <= 16'd1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    tx_ready = 1'b0;
    txd      = 1'b1;
    case (state_q)
      SER_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          state_d = SER_START;
          shreg_d = tx_byte;
          div_d   = eff_div(divisor);
          cnt_d   = '0;
        end
      end
      SER_START: begin
        txd = 1'b0;
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = SER_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SER_DATA: begin
        txd = shreg_q[0];
        if (bit_end) begin
          cnt_d   = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = SER_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SER_STOP: begin
        txd = 1'b1;
        if (bit_end) begin
          // Accepting on the last stop clock lets frames run back to back.
          tx_ready = 1'b1;
          if (tx_valid) begin
            state_d = SER_START;
            shreg_d = tx_byte;
            div_d   = eff_div(divisor);
            cnt_d   = '0;
          end else begin
            state_d = SER_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

endmodule

// File: rtl/axil_uart_tx.sv
// AXI4-Lite register front end for a UART transmitter: TXDATA/STATUS/DIVISOR
// registers, a TX byte FIFO, and the serializer sub-module.
module axil_uart_tx
  import axil_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        AXI_CLK,
  input  logic        RESET,
  input  logic [31:0] AXI_awaddr,
  input  logic [2:0]  AXI_awprot,
  input  logic        AXI_awvalid,
  output logic        AXI_awready,
  input  logic [31:0] AXI_wdata,
  input  logic [3:0]  AXI_wstrb,
  input  logic        AXI_wvalid,
  output logic        AXI_wready,
  output logic [1:0]  AXI_bresp,
  output logic        AXI_bvalid,
  input  logic        AXI_bready,
  input  logic [31:0] AXI_araddr,
  input  logic [2:0]  AXI_arprot,
  input  logic        AXI_arvalid,
  output logic        AXI_arready,
  output logic [31:0] AXI_rdata,
  output logic [1:0]  AXI_rresp,
  output logic        AXI_rvalid,
  input  logic        AXI_rready,
  output logic        TXD
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic          rst_done;
  logic          aw_cap, w_cap;
  logic [31:0]   awaddr_q, wdata_q;
  logic [3:0]    wstrb_q;
  logic          bvalid_q, rvalid_q;
  logic [1:0]    bresp_q, rresp_q;
  logic [31:0]   rdata_q;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   divisor;

  logic          aw_hs, w_hs, ar_hs, do_write;
  logic [31:0]   wr_addr, wr_data;
  logic [3:0]    wr_strb;
  logic          wr_mapped, rd_mapped;
  logic          fifo_full, fifo_empty;
  logic          push_req, push, pop, ovf_set, ovf_clr, div_wr;
  logic [1:0]    wr_resp;
  logic [31:0]   rd_val;
  logic          ser_ready, tx_busy;
  logic [7:0]    fifo_head;

  assign AXI_awready = rst_done && !aw_cap && !bvalid_q;
  assign AXI_wready  = rst_done && !w_cap && !bvalid_q;
  assign AXI_arready = rst_done && !rvalid_q;
  assign AXI_bvalid  = bvalid_q;
  assign AXI_bresp   = bresp_q;
  assign AXI_rvalid  = rvalid_q;
  assign AXI_rresp   = rresp_q;
  assign AXI_rdata   = rdata_q;

  assign aw_hs = AXI_awvalid && AXI_awready;
  assign w_hs  = AXI_wvalid && AXI_wready;
  assign ar_hs = AXI_arvalid && AXI_arready;

  // A live handshake stands in for a captured channel, so a write completes
  // on the same edge as whichever of AW/W arrives last.
  assign wr_addr  = aw_cap ? awaddr_q : AXI_awaddr;
  assign wr_data  = w_cap ? wdata_q : AXI_wdata;
  assign wr_strb  = w_cap ? wstrb_q : AXI_wstrb;
  assign do_write = (aw_cap || aw_hs) && (w_cap || w_hs);

  assign wr_mapped = (wr_addr[31:4] == BASE_ADDR[31:4]) && (wr_addr[3:2] != 2'd3);
  assign rd_mapped = (AXI_araddr[31:4] == BASE_ADDR[31:4]) && (AXI_araddr[3:2] != 2'd3);

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign fifo_head  = fifo_mem[rd_ptr];

  assign push_req = do_write && wr_mapped && (wr_addr[3:2] == OFF_TXDATA) && wr_strb[0];
  assign push     = push_req && !fifo_full;
  assign ovf_set  = push_req && fifo_full;
  assign ovf_clr  = do_write && wr_mapped && (wr_addr[3:2] == OFF_STATUS) && wr_strb[0] && wr_data[3];
  assign div_wr   = do_write && wr_mapped && (wr_addr[3:2] == OFF_DIVISOR);
  assign wr_resp  = (!wr_mapped || ovf_set) ? RESP_SLVERR : RESP_OKAY;
  assign pop      = ser_ready && !fifo_empty;

  always_comb begin
    rd_val = '0;
    if (rd_mapped) begin
      case (AXI_araddr[3:2])
        OFF_STATUS: begin
          rd_val[ST_FULL]                   = fifo_full;
          rd_val[ST_EMPTY]                  = fifo_empty;
          rd_val[ST_BUSY]                   = tx_busy;
          rd_val[ST_OVF]                    = overflow;
          rd_val[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(count);
        end
        OFF_DIVISOR: rd_val[15:0] = divisor;
        default: rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge AXI_CLK) begin
    if (RESET) begin
      rst_done <= 1'b0;
      aw_cap   <= 1'b0;
      w_cap    <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
      rvalid_q <= 1'b0;
      rresp_q  <= '0;
      rdata_q  <= '0;
    end else begin
      rst_done <= 1'b1;
      if (do_write) begin
        aw_cap   <= 1'b0;
        w_cap    <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
      end else begin
        if (aw_hs) begin
          aw_cap   <= 1'b1;
          awaddr_q <= AXI_awaddr;
        end
        if (w_hs) begin
          w_cap   <= 1'b1;
          wdata_q <= AXI_wdata;
          wstrb_q <= AXI_wstrb;
        end
        if (bvalid_q && AXI_bready) bvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
        rresp_q  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && AXI_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge AXI_CLK) begin
    if (push) fifo_mem[wr_ptr] <= wr_data[7:0];
  end

  always_ff @(posedge AXI_CLK) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      divisor  <= DEFAULT_DIV;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (div_wr && wr_strb[0]) divisor[7:0]  <= wr_data[7:0];
      if (div_wr && wr_strb[1]) divisor[15:8] <= wr_data[15:8];
    end
  end

  uart_tx_serializer u_ser (
    .AXI_CLK  (AXI_CLK),
    .RESET    (RESET),
    .tx_byte  (fifo_head),
    .tx_valid (!fifo_empty),
    .tx_ready (ser_ready),
    .divisor  (divisor),
    .txd      (TXD),
    .busy     (tx_busy)
  );

  logic unused_bits;
  assign unused_bits = ^{AXI_awprot, AXI_arprot, AXI_araddr[1:0], wr_addr[1:0],
                         wr_data[31:16], wr_data[7:4], wr_data[2:0], wr_strb[3:2]};

endmodule
